eep_ram_bridge: RTL and testbench
=================================

EEP_RAM_BRIDGE -- requirements
Module: eep_ram_bridge

Interface
REQ-001 Parameter: ADDR_W, default 16, width of every address port.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 eep_addr  in  ADDR_W  save-RAM address from the EEPROM emulator.
REQ-005 eep_di  in  8  write data from the emulator.
REQ-006 eep_do  out  8  registered read data returned to the emulator.
REQ-007 eep_oe / eep_we  in  1 each  emulator read/write strobes, level, held 4 cycles.
REQ-008 host_req  in  1  host access request, level, held until host_ack.
REQ-009 host_we  in  1  1 = write, 0 = read; stable while host_req is high.
REQ-010 host_addr / host_di  in  ADDR_W / 8  host address and write data; stable while host_req is high.
REQ-011 host_do  out  8  host read data.
REQ-012 host_ack  out  1  one-cycle completion pulse.
REQ-013 mem_addr / mem_di  out  ADDR_W / 8  registered memory address and write data.
REQ-014 mem_oe / mem_we  out  1 each  registered memory strobes, one cycle per access.
REQ-015 mem_do  in  8  memory read data, valid exactly 1 cycle after the mem_oe cycle.
REQ-016 dirty  out  1  set by any emulator write since the last clear.
REQ-017 dirty_clr  in  1  one-cycle clear pulse for dirty and wr_cnt.
REQ-018 wr_cnt  out  16  count of emulator writes since the last clear.

Function
REQ-019 The block SHALL detect an emulator request as a rising edge of eep_oe or eep_we (previous cycle low, current cycle high); held levels SHALL NOT generate further accesses.
REQ-020 When eep_oe and eep_we rise in the same cycle, the block SHALL perform the write only and drop the read.
REQ-021 In detection cycle N, the block SHALL register eep_addr and eep_di and drive one memory access in cycle N+1.
REQ-022 For an emulator read, eep_do SHALL be loaded from mem_do at the end of N+2 and be valid from N+3 until the next emulator read completes.
REQ-023 An emulator edge SHALL always win the memory slot for cycle N+1; the host SHALL be deferred, never cancelled.
REQ-024 The read pipeline SHALL carry a 1-bit owner tag (eep/host) so that the captured mem_do is steered only to its issuer.
REQ-025 The host FSM SHALL have three states: H_IDLE, H_BUSY, H_DONE.
REQ-026 Host FSM, H_IDLE: if host_req = 1 and there is no emulator edge this cycle, issue the host access for the next cycle and go to H_BUSY.
REQ-027 Host FSM, H_BUSY: a 2-cycle counter runs; on expiry, assert host_ack for one cycle (host_do valid in that same cycle for reads) and go to H_DONE. Ack therefore falls 3 cycles after the issue decision, for both reads and writes.
REQ-028 Host FSM, H_DONE: wait for host_req = 0, then return to H_IDLE; no second access is allowed while req stays high.
REQ-029 host_do SHALL hold its value until the next host read completes.
REQ-030 Outside issued cycles, mem_oe and mem_we SHALL be 0; mem_oe and mem_we SHALL never both be 1.
REQ-031 Each emulator write SHALL set dirty and increment wr_cnt; wr_cnt SHALL saturate at 16'hFFFF.
REQ-032 dirty_clr SHALL clear dirty and wr_cnt. If it coincides with an emulator write issue, the result SHALL be dirty = 1 and wr_cnt = 1.
REQ-033 Host writes SHALL NOT affect dirty or wr_cnt.
REQ-034 Addresses SHALL pass through unmodified, with no wrap or masking.

Reset
REQ-035 On rst, the block SHALL set mem_oe = mem_we = 0, host_ack = 0, dirty = 0, wr_cnt = 0, eep_do = 8'h00, host_do = 8'h00, and the host FSM to H_IDLE.
REQ-036 On rst, the block SHALL clear edge history to 0, so that a strobe already high when reset drops counts as a new edge.
REQ-037 Reset mid-access SHALL abort in-flight accesses, and no ack SHALL follow. A host_req still high after reset SHALL be served as a new request.

Verification
REQ-038 Memory holds 8'hA5 at address 16'h0012; eep_oe rises in cycle N with eep_addr = 16'h0012 -> mem_oe = 1 at N+1 only, and eep_do = 8'hA5 at N+3.
REQ-039 eep_we held 4 cycles with addr 16'h0040 and data 8'h3C -> exactly one mem_we pulse with mem_di = 8'h3C; dirty = 1 and wr_cnt = 1.
REQ-040 A host read becomes eligible in the same cycle as an eep_oe edge -> the emulator access goes first, the host access is issued the next cycle, host_ack follows 3 cycles later, and both read data values are correct.
REQ-041 eep_oe and eep_we rise together -> one mem_we and no mem_oe.
REQ-042 dirty_clr coincides with an emulator write -> dirty = 1 and wr_cnt = 1. Preloading wr_cnt = 16'hFFFF and doing one more write -> wr_cnt stays 16'hFFFF.
REQ-043 rst is asserted during H_BUSY while host_req stays high -> no ack during reset; after reset, exactly one ack occurs and host_do holds the correct data.

Source files
------------

// File: rtl/eep_ram_bridge.sv
// eep_ram_bridge: arbitrates one save-RAM port between an EEPROM emulator and
// a host, with emulator priority, an owner-tagged read pipeline and dirty tracking.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   eep_addr/di/oe/we    emulator request (strobes are levels; rising edge = access)
//   eep_do               registered emulator read data
//   host_req/we/addr/di  host request, level, held until host_ack
//   host_do, host_ack    host read data and one-cycle completion pulse
//   mem_addr/di/oe/we    registered memory port, one strobe cycle per access
//   mem_do               memory read data, valid the cycle after mem_oe
//   dirty, wr_cnt        emulator write tracking, cleared by dirty_clr
module eep_ram_bridge #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] eep_addr,
    input  logic [7:0]        eep_di,
    output logic [7:0]        eep_do,
    input  logic              eep_oe,
    input  logic              eep_we,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_di,
    output logic [7:0]        host_do,
    output logic              host_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_di,
    output logic              mem_oe,
    output logic              mem_we,
    input  logic [7:0]        mem_do,
    output logic              dirty,
    input  logic              dirty_clr,
    output logic [15:0]       wr_cnt
);

    localparam logic [1:0] H_IDLE = 2'd0;
    localparam logic [1:0] H_BUSY = 2'd1;
    localparam logic [1:0] H_DONE = 2'd2;

    localparam logic OWN_EEP  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    // Edge history
    logic oe_prev_q, oe_prev_d;
    logic we_prev_q, we_prev_d;

    // Memory port
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_di_q, mem_di_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic              own_q, own_d;

    // Capture stage: read data arrives one cycle after the strobe
    logic cap_vld_q, cap_vld_d;
    logic cap_own_q, cap_own_d;

    // Read data registers
    logic [7:0] eep_do_q, eep_do_d;
    logic [7:0] host_do_q, host_do_d;

    // Host FSM
    logic [1:0] state_q, state_d;
    logic       cnt_q, cnt_d;
    logic       ack_q, ack_d;

    // Write tracking
    logic        dirty_q, dirty_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    logic oe_edge;
    logic we_edge;
    logic eep_hit;
    logic host_go;

    assign oe_edge = eep_oe & ~oe_prev_q;
    assign we_edge = eep_we & ~we_prev_q;
    assign eep_hit = oe_edge | we_edge;

    // Host may only take a slot the emulator does not claim
    assign host_go = (state_q == H_IDLE) & host_req & ~eep_hit;

    always_comb begin
        oe_prev_d  = eep_oe;
        we_prev_d  = eep_we;

        mem_addr_d = mem_addr_q;
        mem_di_d   = mem_di_q;
        mem_oe_d   = 1'b0;
        mem_we_d   = 1'b0;
        own_d      = own_q;

        if (eep_hit) begin
            mem_addr_d = eep_addr;
            mem_di_d   = eep_di;
            // Simultaneous edges: the write wins, the read is dropped
            mem_we_d   = we_edge;
            mem_oe_d   = ~we_edge;
            own_d      = OWN_EEP;
        end else if (host_go) begin
            mem_addr_d = host_addr;
            mem_di_d   = host_di;
            mem_we_d   = host_we;
            mem_oe_d   = ~host_we;
            own_d      = OWN_HOST;
        end
    end

    always_comb begin
        cap_vld_d = mem_oe_q;
        cap_own_d = own_q;
        eep_do_d  = eep_do_q;
        host_do_d = host_do_q;

        if (cap_vld_q) begin
            if (cap_own_q == OWN_EEP) begin
                eep_do_d = mem_do;
            end else begin
                host_do_d = mem_do;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;

        case (state_q)
            H_IDLE: begin
                cnt_d = 1'b0;
                if (host_go) begin
                    state_d = H_BUSY;
                end
            end
            H_BUSY: begin
                // Second BUSY cycle is when host read data is captured,
                // so the ack lines up with host_do being valid
                if (cnt_q) begin
                    cnt_d   = 1'b0;
                    ack_d   = 1'b1;
                    state_d = H_DONE;
                end else begin
                    cnt_d = 1'b1;
                end
            end
            H_DONE: begin
                if (!host_req) begin
                    state_d = H_IDLE;
                end
            end
            default: begin
                state_d = H_IDLE;
                cnt_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        dirty_d  = dirty_q;
        wr_cnt_d = wr_cnt_q;

        if (we_edge) begin
            // A clear in the same cycle still leaves this write counted
            dirty_d = 1'b1;
            if (dirty_clr) begin
                wr_cnt_d = 16'd1;
            end else if (wr_cnt_q != 16'hFFFF) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
        end else if (dirty_clr) begin
            dirty_d  = 1'b0;
            wr_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oe_prev_q  <= 1'b0;
            we_prev_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_di_q   <= 8'h00;
            mem_oe_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            own_q      <= OWN_EEP;
            cap_vld_q  <= 1'b0;
            cap_own_q  <= OWN_EEP;
            eep_do_q   <= 8'h00;
            host_do_q  <= 8'h00;
            state_q    <= H_IDLE;
            cnt_q      <= 1'b0;
            ack_q      <= 1'b0;
            dirty_q    <= 1'b0;
            wr_cnt_q   <= 16'd0;
        end else begin
            oe_prev_q  <= oe_prev_d;
            we_prev_q  <= we_prev_d;
            mem_addr_q <= mem_addr_d;
            mem_di_q   <= mem_di_d;
            mem_oe_q   <= mem_oe_d;
            mem_we_q   <= mem_we_d;
            own_q      <= own_d;
            cap_vld_q  <= cap_vld_d;
            cap_own_q  <= cap_own_d;
            eep_do_q   <= eep_do_d;
            host_do_q  <= host_do_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            dirty_q    <= dirty_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_di   = mem_di_q;
    assign mem_oe   = mem_oe_q;
    assign mem_we   = mem_we_q;
    assign eep_do   = eep_do_q;
    assign host_do  = host_do_q;
    assign host_ack = ack_q;
    assign dirty    = dirty_q;
    assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_eep_ram_bridge.sv
// tb_eep_ram_bridge: directed self-checking bench for eep_ram_bridge
// with a behavioural 64K x 8 memory (read data one cycle after mem_oe).
module tb_eep_ram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] eep_addr;
    logic [7:0]  eep_di;
    logic [7:0]  eep_do;
    logic        eep_oe;
    logic        eep_we;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [7:0]  host_di;
    logic [7:0]  host_do;
    logic        host_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic        mem_oe;
    logic        mem_we;
    logic [7:0]  mem_do;
    logic        dirty;
    logic        dirty_clr;
    logic [15:0] wr_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];

    eep_ram_bridge #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .eep_addr  (eep_addr),
        .eep_di    (eep_di),
        .eep_do    (eep_do),
        .eep_oe    (eep_oe),
        .eep_we    (eep_we),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_di   (host_di),
        .host_do   (host_do),
        .host_ack  (host_ack),
        .mem_addr  (mem_addr),
        .mem_di    (mem_di),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .mem_do    (mem_do),
        .dirty     (dirty),
        .dirty_clr (dirty_clr),
        .wr_cnt    (wr_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_oe) mem_do <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_di;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({mem_oe, mem_we, host_ack, dirty} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {mem_oe, mem_we, host_ack, dirty});
        end
        total++;
        if (wr_cnt !== 16'h0000) begin
            bad++;
            $display("FAIL reset_wr_cnt got=%h exp=0000", wr_cnt);
        end
        total++;
        if ({eep_do, host_do} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0000", {eep_do, host_do});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_eep_read;
        int n_oe;
        eep_addr = 16'h0012;
        eep_oe   = 1'b1;
        total++;
        if (mem_oe !== 1'b0) begin
            bad++;
            $display("FAIL rd_n_oe got=%b exp=0", mem_oe);
        end
        tick();
        total++;
        if (mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0012) begin
            bad++;
            $display("FAIL rd_n1 got=oe%b we%b a%h exp=oe1 we0 a0012",
                     mem_oe, mem_we, mem_addr);
        end
        n_oe = 0;
        tick();
        if (mem_oe) n_oe++;
        tick();
        if (mem_oe) n_oe++;
        total++;
        if (eep_do !== 8'hA5) begin
            bad++;
            $display("FAIL rd_n3_data got=%h exp=a5", eep_do);
        end
        eep_oe = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_oe) n_oe++;
        end
        total++;
        if (n_oe !== 0) begin
            bad++;
            $display("FAIL rd_extra_oe got=%0d exp=0", n_oe);
        end
    endtask

    task automatic test_eep_write;
        int n_we;
        logic [15:0] a_seen;
        logic [7:0]  d_seen;
        n_we   = 0;
        a_seen = 16'h0;
        d_seen = 8'h0;
        eep_addr = 16'h0040;
        eep_di   = 8'h3C;
        eep_we   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) eep_we = 1'b0;
            if (mem_we) begin
                n_we++;
                a_seen = mem_addr;
                d_seen = mem_di;
            end
        end
        total++;
        if (n_we !== 1 || a_seen !== 16'h0040 || d_seen !== 8'h3C) begin
            bad++;
            $display("FAIL wr_pulse got=n%0d a%h d%h exp=n1 a0040 d3c",
                     n_we, a_seen, d_seen);
        end
        total++;
        if (dirty !== 1'b1 || wr_cnt !== 16'd1) begin
            bad++;
            $display("FAIL wr_dirty got=%b/%h exp=1/0001", dirty, wr_cnt);
        end
        total++;
        if (mem[16'h0040] !== 8'h3C) begin
            bad++;
            $display("FAIL wr_mem got=%h exp=3c", mem[16'h0040]);
        end
    endtask

    task automatic test_both_edges;
        int n_we;
        int n_oe;
        n_we = 0;
        n_oe = 0;
        eep_addr = 16'h0041;
        eep_di   = 8'h11;
        eep_oe   = 1'b1;
        eep_we   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) begin
                eep_oe = 1'b0;
                eep_we = 1'b0;
            end
            if (mem_we) n_we++;
            if (mem_oe) n_oe++;
        end
        total++;
        if (n_we !== 1 || n_oe !== 0) begin
            bad++;
            $display("FAIL both_edges got=we%0d oe%0d exp=we1 oe0", n_we, n_oe);
        end
        total++;
        if (wr_cnt !== 16'd2) begin
            bad++;
            $display("FAIL both_wr_cnt got=%h exp=0002", wr_cnt);
        end
    endtask

    task automatic test_collide;
        eep_addr  = 16'h0013;
        eep_oe    = 1'b1;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h0077;
        tick();
        total++;
        if (mem_oe !== 1'b1 || mem_addr !== 16'h0013) begin
            bad++;
            $display("FAIL col_n1 got=oe%b a%h exp=oe1 a0013", mem_oe, mem_addr);
        end
        tick();
        total++;
        if (mem_oe !== 1'b1 || mem_addr !== 16'h0077) begin
            bad++;
            $display("FAIL col_n2 got=oe%b a%h exp=oe1 a0077", mem_oe, mem_addr);
        end
        tick();
        total++;
        if (host_ack !== 1'b0 || eep_do !== 8'hC3) begin
            bad++;
            $display("FAIL col_n3 got=ack%b d%h exp=ack0 dc3", host_ack, eep_do);
        end
        tick();
        total++;
        if (host_ack !== 1'b1 || host_do !== 8'h5A) begin
            bad++;
            $display("FAIL col_n4 got=ack%b d%h exp=ack1 d5a", host_ack, host_do);
        end
        host_req = 1'b0;
        eep_oe   = 1'b0;
        tick();
        total++;
        if (host_ack !== 1'b0 || eep_do !== 8'hC3) begin
            bad++;
            $display("FAIL col_n5 got=ack%b d%h exp=ack0 dc3", host_ack, eep_do);
        end
        tick();
    endtask

    task automatic test_host_write;
        int n_acc;
        host_req  = 1'b1;
        host_we   = 1'b1;
        host_addr = 16'h0050;
        host_di   = 8'h99;
        tick();
        total++;
        if (mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== 16'h0050 ||
            mem_di !== 8'h99) begin
            bad++;
            $display("FAIL hw_issue got=we%b oe%b a%h d%h exp=we1 oe0 a0050 d99",
                     mem_we, mem_oe, mem_addr, mem_di);
        end
        tick();
        tick();
        total++;
        if (host_ack !== 1'b1 || host_do !== 8'h5A) begin
            bad++;
            $display("FAIL hw_ack got=ack%b d%h exp=ack1 d5a", host_ack, host_do);
        end
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_we || mem_oe || host_ack) n_acc++;
        end
        total++;
        if (n_acc !== 0) begin
            bad++;
            $display("FAIL hw_done_hold got=%0d exp=0", n_acc);
        end
        total++;
        if (dirty !== 1'b1 || wr_cnt !== 16'd2) begin
            bad++;
            $display("FAIL hw_dirty got=%b/%h exp=1/0002", dirty, wr_cnt);
        end
        host_req = 1'b0;
        tick();
        host_req = 1'b1;
        host_we  = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (host_ack !== 1'b1 || host_do !== 8'h99) begin
            bad++;
            $display("FAIL hw_readback got=ack%b d%h exp=ack1 d99",
                     host_ack, host_do);
        end
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_dirty_clr;
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        total++;
        if (dirty !== 1'b0 || wr_cnt !== 16'd0) begin
            bad++;
            $display("FAIL clr_only got=%b/%h exp=0/0000", dirty, wr_cnt);
        end
        eep_addr  = 16'h0060;
        eep_di    = 8'h01;
        eep_we    = 1'b1;
        tick();
        eep_we = 1'b0;
        tick();
        eep_we    = 1'b1;
        dirty_clr = 1'b1;
        tick();
        dirty_clr = 1'b0;
        total++;
        if (dirty !== 1'b1 || wr_cnt !== 16'd1) begin
            bad++;
            $display("FAIL clr_coincide got=%b/%h exp=1/0001", dirty, wr_cnt);
        end
        eep_we = 1'b0;
        tick();
        force dut.wr_cnt_q = 16'hFFFF;
        tick();
        release dut.wr_cnt_q;
        tick();
        total++;
        if (wr_cnt !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_preload got=%h exp=ffff", wr_cnt);
        end
        eep_we = 1'b1;
        tick();
        eep_we = 1'b0;
        tick();
        total++;
        if (wr_cnt !== 16'hFFFF || dirty !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold got=%b/%h exp=1/ffff", dirty, wr_cnt);
        end
    endtask

    task automatic test_reset_busy;
        int n_ack;
        logic [7:0] d_ack;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 16'h0077;
        tick();
        tick();
        rst = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (host_ack) n_ack++;
        end
        total++;
        if (n_ack !== 0 || host_do !== 8'h00) begin
            bad++;
            $display("FAIL rstb_during got=n%0d d%h exp=n0 d00", n_ack, host_do);
        end
        rst = 1'b0;
        n_ack = 0;
        d_ack = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (host_ack) begin
                n_ack++;
                d_ack = host_do;
            end
        end
        total++;
        if (n_ack !== 1 || d_ack !== 8'h5A) begin
            bad++;
            $display("FAIL rstb_after got=n%0d d%h exp=n1 d5a", n_ack, d_ack);
        end
        host_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_edge;
        rst      = 1'b1;
        eep_addr = 16'h0012;
        eep_oe   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (mem_oe !== 1'b1 || mem_addr !== 16'h0012) begin
            bad++;
            $display("FAIL rste_oe got=oe%b a%h exp=oe1 a0012", mem_oe, mem_addr);
        end
        tick();
        tick();
        total++;
        if (eep_do !== 8'hA5) begin
            bad++;
            $display("FAIL rste_data got=%h exp=a5", eep_do);
        end
        eep_oe = 1'b0;
        tick();
    endtask

    initial begin
        mem[16'h0012] = 8'hA5;
        mem[16'h0013] = 8'hC3;
        mem[16'h0077] = 8'h5A;
        mem_do    = 8'h00;
        rst       = 1'b1;
        eep_addr  = 16'h0;
        eep_di    = 8'h0;
        eep_oe    = 1'b0;
        eep_we    = 1'b0;
        host_req  = 1'b0;
        host_we   = 1'b0;
        host_addr = 16'h0;
        host_di   = 8'h0;
        dirty_clr = 1'b0;
        test_reset();
        test_eep_read();
        test_eep_write();
        test_both_edges();
        test_collide();
        test_host_write();
        test_dirty_clr();
        test_reset_busy();
        test_reset_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
